stack_sequencer: RTL

//  Sequences the data stack for the 16-bit stack processor. Executes the decoded stackOP codes
//  (NONE/PUSH/POPANDREPLACE/POP/POP2/SWAP) on a stack of TOS/NOS registers backed by a

---
 rtl/stack_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// Data-stack sequencer: TOS/NOS held in registers, deeper entries spilled to a single-port
// synchronous RAM on push and refilled on pop, with sticky overflow/underflow flags.
module stack_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] wdata,
    output logic             op_ready,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [AW:0]      depth,
    output logic             overflow,
    output logic             underflow,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_we,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_PAR   = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_POP2  = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;

    localparam logic [AW:0] D0   = (AW+1)'(0);
    localparam logic [AW:0] D1   = (AW+1)'(1);
    localparam logic [AW:0] D2   = (AW+1)'(2);
    localparam logic [AW:0] D3   = (AW+1)'(3);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL1 = 2'd1, FILL2A = 2'd2, FILL2B = 2'd3} state_t;
    state_t state;

    logic [AW:0] d_m2;
    logic [AW:0] d_m3;

    // Handshake: an op transfers on a rising edge where op_valid && op_ready; op_ready is high
    // only in IDLE, and op_valid is ignored while a refill is outstanding.
    assign op_ready  = (state == IDLE);
    assign dbg_state = state;
    assign ram_wdata = nos;
    assign d_m2      = depth - D2;
    assign d_m3      = depth - D3;

    // RAM holds elements 0..d-3; addresses below are relative to the pre-op depth.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_PUSH: begin
                            if (depth != FULL && depth >= D2) begin
                                ram_we   = 1'b1;
                                ram_addr = d_m2[AW-1:0];
                            end
                        end
                        OP_POP, OP_PAR, OP_POP2: begin
                            if (depth >= D3) ram_addr = d_m3[AW-1:0];
                        end
                        default: ;
                    endcase
                end
            end
            // depth already holds d-2 here, so the second POP2 word sits at depth-2.
            FILL2A: if (depth >= D2) ram_addr = d_m2[AW-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tos       <= '0;
            nos       <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_PUSH: begin
                                if (depth == FULL) overflow <= 1'b1;
                                else begin
                                    nos   <= tos;
                                    tos   <= wdata;
                                    depth <= depth + D1;
                                end
                            end
                            OP_SWAP: begin
                                if (depth < D2) underflow <= 1'b1;
                                else begin
                                    tos <= nos;
                                    nos <= tos;
                                end
                            end
                            OP_POP, OP_PAR: begin
                                if ((op == OP_POP && depth == D0) || (op == OP_PAR && depth < D2))
                                    underflow <= 1'b1;
                                else begin
                                    tos   <= (op == OP_POP) ? nos : wdata;
                                    depth <= depth - D1;
                                    if (depth >= D3) state <= FILL1;
                                    else nos <= '0;
                                end
                            end
                            OP_POP2: begin
                                if (depth < D2) underflow <= 1'b1;
                                else begin
                                    depth <= depth - D2;
                                    if (depth >= D3) begin
                                        state <= FILL2A;
                                        if (depth == D3) nos <= '0;
                                    end else begin
                                        tos <= '0;
                                        nos <= '0;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FILL1: begin
                    nos   <= ram_rdata;
                    state <= IDLE;
                end
                FILL2A: begin
                    tos   <= ram_rdata;
                    state <= (depth >= D2) ? FILL2B : IDLE;
                end
                FILL2B: begin
                    nos   <= ram_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
